// File: rtl/cpu_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_fsm
//   Multi-cycle control FSM for the 3-bit-opcode CPU datapath. It sequences
//   FETCH -> DECODE -> EXEC -> (MEM) -> (WB) for one instruction at a time
//   and drives the PC, IR, register-file, ALU and memory-strobe enables.
//
//   ISA: 0 LD, 1 ST, 2 BEQ, 3 BNE, 4 ADD, 5 SUB, 6 AND, 7 OR.
//
//   Optional feature macro: CTRL_MEM_TIMEOUT_EN
//     Defined     : imem/dmem waits are bounded by TIMEOUT_CYC cycles.
//                   Expiry enters ERROR, where err=1 until rst_n.
//     Not defined : waits are unbounded, err is always 0.
//
// Parameters
//   CNT_W        width of the retired-instruction counter
//   TIMEOUT_CYC  maximum wait cycles for an ack (timeout build only)
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   start, stop          run control (stop lets the current instruction finish)
//   opcode               decoder opcode, valid from DECODE onward
//   zero_flag            ALU compare result for branches
//   imem_ack, dmem_ack   memory handshakes
//   imem_req, ir_load    instruction fetch request / IR load
//   pc_inc, pc_load      PC increment / branch-taken load
//   rf_we, rf_wsel       register-file write enable / write-data select
//   alu_op               00 ADD, 01 SUB, 10 AND, 11 OR
//   dmem_re, dmem_we     data memory read / write strobes
//   busy                 high in every state except IDLE and ERROR
//   instr_count          retired-instruction count, wraps
//   err                  sticky memory-timeout flag
// ---------------------------------------------------------------------------
module cpu_ctrl_fsm #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [2:0]       opcode,
  input  logic             zero_flag,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             rf_we,
  output logic             rf_wsel,
  output logic [1:0]       alu_op,
  output logic             dmem_re,
  output logic             dmem_we,
  output logic             busy,
  output logic [CNT_W-1:0] instr_count,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_ERROR
  } state_t;

  localparam logic [2:0] OP_LD = 3'd0;
  localparam logic [2:0] OP_ST = 3'd1;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] op_q;       // opcode captured in DECODE, used for MEM/WB routing
  logic       stop_pend;
  logic       retire;
  logic       timeout;
  logic       busy_state;

  assign busy_state = (state != S_IDLE) && (state != S_ERROR);

  // IR load is the one output that follows the handshake combinationally so
  // the IR captures the data in the same cycle imem_ack is seen.
  assign ir_load = (state == S_FETCH) && imem_ack;

`ifdef CTRL_MEM_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WAIT_W-1:0] wait_cnt;

  // True in the cycle where one more ack-less cycle reaches the limit.
  assign timeout = ({1'b0, wait_cnt} + (WAIT_W+1)'(1)) == (WAIT_W+1)'(TIMEOUT_CYC);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign timeout            = 1'b0;
`endif

  // Next-state logic.
  // NOTE: every signal written in always_comb gets a default first, otherwise
  // paths that skip an assignment infer a latch.
  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    unique case (state)
      S_IDLE:   if (start && !stop) state_nxt = S_FETCH;
      S_FETCH: begin
        // An ack in the same cycle the limit is reached wins.
        if (imem_ack)     state_nxt = S_DECODE;
        else if (timeout) state_nxt = S_ERROR;
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        if (op_q == OP_LD || op_q == OP_ST) state_nxt = S_MEM;
        else if (op_q[2])                   state_nxt = S_WB;
        else                                retire    = 1'b1;   // BEQ/BNE
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (op_q == OP_LD) state_nxt = S_WB;
          else               retire    = 1'b1;
        end else if (timeout) begin
          state_nxt = S_ERROR;
        end
      end
      S_WB:     retire    = 1'b1;
      S_ERROR:  state_nxt = S_ERROR;
      default:  state_nxt = S_IDLE;
    endcase
    if (retire) state_nxt = (stop_pend || stop) ? S_IDLE : S_FETCH;
  end

  // State, bookkeeping and registered outputs. Outputs are decoded from
  // state_nxt so each one is valid for exactly the cycle its state is active.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op_q        <= 3'd0;
      stop_pend   <= 1'b0;
      instr_count <= '0;
      imem_req    <= 1'b0;
      pc_inc      <= 1'b0;
      pc_load     <= 1'b0;
      rf_we       <= 1'b0;
      rf_wsel     <= 1'b0;
      alu_op      <= 2'b00;
      dmem_re     <= 1'b0;
      dmem_we     <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
`ifdef CTRL_MEM_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      state <= state_nxt;

      if (state == S_DECODE) op_q <= opcode;

      if (retire) begin
        instr_count <= instr_count + CNT_W'(1);
        stop_pend   <= 1'b0;
      end else if (busy_state && stop) begin
        stop_pend <= 1'b1;
      end

      imem_req <= (state_nxt == S_FETCH);
      pc_inc   <= (state_nxt == S_DECODE);
      rf_we    <= (state_nxt == S_WB);
      rf_wsel  <= (state_nxt == S_WB) && (op_q == OP_LD);
      dmem_re  <= (state_nxt == S_MEM) && (op_q == OP_LD);
      dmem_we  <= (state_nxt == S_MEM) && (op_q == OP_ST);
      busy     <= (state_nxt != S_IDLE) && (state_nxt != S_ERROR);
      err      <= (state_nxt == S_ERROR);

      // DECODE always moves to EXEC, so the EXEC-cycle ALU op and branch
      // decision are registered from the opcode and flag seen in DECODE.
      if (state == S_DECODE) begin
        if (opcode[2])      alu_op <= opcode[1:0];
        else if (opcode[1]) alu_op <= 2'b01;        // branch compare = SUB
        else                alu_op <= 2'b00;
        pc_load <= (opcode[2:1] == 2'b01) && (zero_flag ^ opcode[0]);
      end else begin
        alu_op  <= 2'b00;
        pc_load <= 1'b0;
      end

`ifdef CTRL_MEM_TIMEOUT_EN
      if ((state_nxt == S_FETCH && state != S_FETCH) ||
          (state_nxt == S_MEM   && state != S_MEM)) begin
        wait_cnt <= '0;
      end else if ((state == S_FETCH && !imem_ack) ||
                   (state == S_MEM   && !dmem_ack)) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
`endif
    end
  end

endmodule
